// File: rtl/reg32_avalon_master.sv
// reg32_avalon_master
//
// Avalon-MM master sequencer for the 32-bit register slave. Commands from a
// local valid/ready stream are buffered in a small FIFO. They are issued on the
// Avalon bus one at a time, and each transfer is held while avm_waitrequest is
// high. A completed read returns its data on a one-cycle rsp_valid strobe.
//
// Parameters
//   DEPTH        command FIFO entries (power of two, >= 2)
//   READ_LATENCY fixed slave read latency in cycles (0..3)
//   TIMEOUT      maximum waitrequest stall cycles (timeout build only)
//
// Ports
//   clock, reset          sole clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is registered
//   cmd_write             1 = write, 0 = read
//   cmd_address           word address
//   cmd_byteenable        write byte lanes
//   cmd_writedata         write data
//   rsp_valid             one-cycle strobe: read complete or transfer timed out
//   rsp_data              captured read data (0 on timeout)
//   rsp_error             qualifies rsp_valid, 1 = timeout
//   avm_*                 registered Avalon-MM master signals
//
// Build option
//   REG32_MASTER_TIMEOUT_EN  when defined, the master abandons a transfer after
//   TIMEOUT stalled cycles and reports it with rsp_error. When undefined, the
//   master waits indefinitely and rsp_error is tied low.

module reg32_avalon_master #(
  parameter int DEPTH        = 4,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_address,
  input  logic [3:0]  cmd_byteenable,
  input  logic [31:0] cmd_writedata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic        avm_read,
  output logic [2:0]  avm_address,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = 2;
  localparam int ENT_W = 40;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("reg32_avalon_master: DEPTH must be a power of two >= 2");
  end
  if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : g_bad_latency
    $error("reg32_avalon_master: READ_LATENCY must be 0..3");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("reg32_avalon_master: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Command FIFO
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cmd_ready_q;
  logic             push, pop, fifo_empty;
  logic [ENT_W-1:0] head;
  logic             head_write;
  logic [2:0]       head_addr;
  logic [3:0]       head_be;
  logic [31:0]      head_data;

  // Bus and response registers
  logic        cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [2:0]  addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic        load, done;

`ifdef REG32_MASTER_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            rsp_error_q, rsp_error_d;
`endif

  assign push       = cmd_valid & cmd_ready_q;
  assign pop        = load;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_write = head[39];
  assign head_addr  = head[38:36];
  assign head_be    = head[35:32];
  assign head_data  = head[31:0];

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_write, cmd_address, cmd_byteenable, cmd_writedata};
    end
  end

  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wd_d        = wd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    lat_d       = lat_q;
    load        = 1'b0;
    done        = 1'b0;
`ifdef REG32_MASTER_TIMEOUT_EN
    rsp_error_d = 1'b0;
    to_cnt_d    = to_cnt_q;
`endif
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (avm_waitrequest) begin
`ifdef REG32_MASTER_TIMEOUT_EN
          if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            cs_d        = 1'b0;
            wr_d        = 1'b0;
            rd_d        = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_data_d  = '0;
            state_d     = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
`endif
        end else if (wr_q) begin
          done = 1'b1;
        end else if (READ_LATENCY == 0) begin
          rsp_data_d  = avm_readdata;
          rsp_valid_d = 1'b1;
          done        = 1'b1;
        end else begin
          // Read accepted; data arrives READ_LATENCY edges later.
          cs_d    = 1'b0;
          rd_d    = 1'b0;
          lat_d   = LAT_W'(1);
          state_d = S_RDWAIT;
        end
        if (done) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            cs_d    = 1'b0;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_RDWAIT: begin
        if (lat_q == LAT_W'(READ_LATENCY)) begin
          rsp_data_d  = avm_readdata;
          rsp_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reads drive all byte lanes and leave the write data bus untouched.
    if (load) begin
      cs_d   = 1'b1;
      wr_d   = head_write;
      rd_d   = !head_write;
      addr_d = head_addr;
      be_d   = head_write ? head_be : 4'hF;
      if (head_write) begin
        wd_d = head_data;
      end
`ifdef REG32_MASTER_TIMEOUT_EN
      to_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      lat_q       <= '0;
`ifdef REG32_MASTER_TIMEOUT_EN
      to_cnt_q    <= '0;
      rsp_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
      cmd_ready_q <= (count_d != CNT_W'(DEPTH));
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wd_q        <= wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      lat_q       <= lat_d;
`ifdef REG32_MASTER_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      rsp_error_q <= rsp_error_d;
`endif
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
`ifdef REG32_MASTER_TIMEOUT_EN
  assign rsp_error      = rsp_error_q;
`else
  assign rsp_error      = 1'b0;
`endif
  assign avm_chipselect = cs_q;
  assign avm_write      = wr_q;
  assign avm_read       = rd_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = wd_q;

endmodule
